// File: rtl/conv_encoder_framed.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination.
// Emits one registered symbol per accepted bit and then K-1 tail symbols per frame.
module conv_encoder_framed #(
    parameter int              K         = 3,
    parameter logic [K-1:0]    G0        = 3'b111,
    parameter logic [K-1:0]    G1        = 3'b101,
    parameter int              FRAME_LEN = 256,
    parameter int              CT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic            d_in,
    output logic            ready_o,
    output logic            valid_o,
    output logic [1:0]      d_out,
    output logic            tail_o,
    output logic            frame_done_o,
    output logic [CT_W-1:0] frame_ct_o,
    output logic [CT_W-1:0] drop_ct_o
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = $clog2(K);

    typedef enum logic {S_DATA, S_TAIL} state_t;

    state_t          r_state;
    logic [K-2:0]    r_sr;
    logic [BW-1:0]   r_bit_ct;
    logic [TW-1:0]   r_tail_ct;
    logic            r_valid;
    logic [1:0]      r_dout;
    logic            r_tail;
    logic            r_fdone;
    logic [CT_W-1:0] r_frame_ct;
    logic [CT_W-1:0] r_drop_ct;

    logic            w_b;
    logic [K-1:0]    w_win;
    logic [1:0]      w_sym;
    logic            w_last_bit;
    logic            w_last_tail;

    // Tail bits are forced to zero so K-1 shifts drain the register back to state 0.
    assign w_b         = (r_state == S_DATA) ? d_in : 1'b0;
    assign w_win       = {w_b, r_sr};
    assign w_sym       = {^(w_win & G0), ^(w_win & G1)};
    assign w_last_bit  = (r_bit_ct == BW'(FRAME_LEN - 1));
    assign w_last_tail = (r_tail_ct == TW'(K - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_DATA;
            r_sr       <= '0;
            r_bit_ct   <= '0;
            r_tail_ct  <= '0;
            r_valid    <= 1'b0;
            r_dout     <= 2'b00;
            r_tail     <= 1'b0;
            r_fdone    <= 1'b0;
            r_frame_ct <= '0;
            r_drop_ct  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_tail  <= 1'b0;
            r_fdone <= 1'b0;
            case (r_state)
                S_DATA: begin
                    if (enable_i) begin
                        r_dout  <= w_sym;
                        r_valid <= 1'b1;
                        r_sr    <= w_win[K-1:1];
                        if (w_last_bit) begin
                            r_bit_ct  <= '0;
                            r_tail_ct <= '0;
                            r_state   <= S_TAIL;
                        end else begin
                            r_bit_ct <= r_bit_ct + 1'b1;
                        end
                    end
                end
                S_TAIL: begin
                    r_dout  <= w_sym;
                    r_valid <= 1'b1;
                    r_tail  <= 1'b1;
                    r_sr    <= w_win[K-1:1];
                    if (enable_i && (r_drop_ct != '1)) begin
                        r_drop_ct <= r_drop_ct + 1'b1;
                    end
                    if (w_last_tail) begin
                        r_fdone    <= 1'b1;
                        r_frame_ct <= r_frame_ct + 1'b1;
                        r_state    <= S_DATA;
                    end else begin
                        r_tail_ct <= r_tail_ct + 1'b1;
                    end
                end
                default: r_state <= S_DATA;
            endcase
        end
    end

    assign ready_o      = (r_state == S_DATA);
    assign valid_o      = r_valid;
    assign d_out        = r_dout;
    assign tail_o       = r_tail;
    assign frame_done_o = r_fdone;
    assign frame_ct_o   = r_frame_ct;
    assign drop_ct_o    = r_drop_ct;

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
Rate-1/2 convolutional encoder with frame termination. It is the transmit end feeding the Viterbi decoder through the channel/error-injection stage. It accepts one data bit per enabled cycle and emits one registered 2-bit symbol per accepted bit. After every FRAME_LEN data bits it appends K-1 zero tail bits, returning the trellis to state 0 so the decoder sees zero-terminated frames.

Parameters:
K, 3, constraint length (3..9); the shift register holds K-1 bits
G0, 3'b111, generator polynomial for d_out[1], K bits wide, MSB taps the current input bit
G1, 3'b101, generator polynomial for d_out[0], K bits wide
FRAME_LEN, 256, data bits per frame (>=1)
CT_W, 16, width of the frame counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
enable_i  input  1  data bit valid this cycle
d_in  input  1  data bit
ready_o  output  1  high when a data bit can be accepted (DATA state)
valid_o  output  1  d_out holds a new symbol this cycle
d_out  output  2  encoded symbol {G0 parity, G1 parity}
tail_o  output  1  current valid symbol is a tail symbol
frame_done_o  output  1  one-cycle pulse with the last tail symbol
frame_ct_o  output  CT_W  completed-frame count, wraps modulo 2**CT_W
drop_ct_o  output  CT_W  count of enable_i cycles ignored while ready_o=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=DATA, sr=0, bit_ct=0, ready_o=1, valid_o=0, d_out=2'b00, tail_o=0, frame_done_o=0, frame_ct_o=0, drop_ct_o=0.
- Encoding window w = {b, sr}, K bits. b is the input bit (d_in in DATA, 0 in TAIL) at bit K-1. sr[K-2] holds the most recent previous bit.
- d_out[1] = XOR-reduce(w & G0). d_out[0] = XOR-reduce(w & G1).
- On each encode, sr <= w[K-1:1].
- Latency: symbol is registered and appears the cycle after the bit is accepted. valid_o is high for exactly one cycle per encoded bit. d_out holds its last value when valid_o=0.
- State DATA:
  - ready_o=1.
  - enable_i=1: encode d_in and increment bit_ct.
  - When bit_ct reaches FRAME_LEN-1 and a bit is accepted: bit_ct<=0, go to TAIL.
  - enable_i=0: no symbol, sr unchanged.
- State TAIL:
  - ready_o=0.
  - Encode b=0 every cycle unconditionally for exactly K-1 cycles; valid_o=1 and tail_o=1 on each of those symbols.
  - The final tail symbol also asserts frame_done_o, and frame_ct_o increments in the same cycle.
  - Then return to DATA with sr=0.
- enable_i=1 while ready_o=0: the bit is discarded, drop_ct_o increments (saturates at all-ones), and encoder state is unaffected.
- Back-to-back frames: the DATA→TAIL transition costs no extra cycle. After the last data symbol, K-1 tail symbols follow on consecutive cycles, then ready_o=1 again.
- Reset mid-frame or mid-tail aborts the frame. No tail is emitted and counters clear.
- ready_o is combinational from state only. It never depends on enable_i.

Test Plan:
- Impulse with defaults (FRAME_LEN=4): bits 1,0,0,0 -> data symbols 11,10,11,00, tail 00,00 with tail_o=1 on last two, frame_done_o on last, frame_ct_o=1.
- Bits 1,0,1,1 (FRAME_LEN=4) -> symbols 11,10,00,01; tail 01,11; sr=0 afterwards; ready_o low exactly 2 cycles.
- enable_i held high continuously through 3 frames (FRAME_LEN=4) -> ready_o pattern 4 high/2 low repeating; drop_ct_o=6; frame_ct_o=3; each valid_o exactly one cycle after acceptance.
- Gapped enable_i (1 every 3 cycles) -> valid_o pulses track accepted bits with 1-cycle latency; d_out stable between pulses; tail still emitted on consecutive cycles.
- Assert rst low during TAIL, release -> all outputs at reset values, next frame's first bit 1 gives symbol 11 (sr cleared).
- Frame counter wrap with CT_W=2 -> after 5 frames frame_ct_o=1; drop_ct_o saturates at 3.
